spi_bus_arbiter: RTL and testbench

Shares the single byte-level SPI shift engine and the flash chip-select between two requesters: requester 0 is the CPU I/O port and requester 1 is the internal flash loader. It grants whole chip-select sessions with round-robin priority and sequences byte starts into the engine. It also screens the first byte of every session against the forbidden dual/quad-I/O command list. A watchdog revokes sessions that stall.

---
 rtl/spi_bus_arbiter_if.sv | 40 ++++
 rtl/spi_bus_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_bus_arbiter_if.sv
// Bus bundle between the two SPI requesters, the shared byte engine and the
// arbiter. The arbiter takes the slave view; requesters/engine (or a bench)
// take the master view.
//
// Handshake: nothing here is valid/ready. Every transfer uses one-cycle
// strobes. A requester holds i_req[n] for a whole chip-select session and
// pulses i_start[n] once per byte, only while o_gnt[n] is high and the
// previous o_done[n] has come back. The arbiter answers each accepted byte
// with exactly one o_done[n] pulse, or ends the session with an o_abort[n]
// pulse. Toward the engine, o_eng_start is a one-cycle request with o_eng_tx
// held stable until the engine's one-cycle i_eng_done, and i_eng_rx is
// sampled only in that cycle.
interface spi_bus_arbiter_if;
    logic [1:0] i_req;
    logic [1:0] o_gnt;
    logic [1:0] i_start;
    logic [7:0] i_tx0;
    logic [7:0] i_tx1;
    logic [1:0] o_done;
    logic [1:0] o_abort;
    logic [7:0] o_rx;
    logic       o_eng_start;
    logic [7:0] o_eng_tx;
    logic       i_eng_done;
    logic [7:0] i_eng_rx;
    logic       o_spi_ss;
    logic [2:0] dbg_state;

    modport slave (
        input  i_req, i_start, i_tx0, i_tx1, i_eng_done, i_eng_rx,
        output o_gnt, o_done, o_abort, o_rx, o_eng_start, o_eng_tx, o_spi_ss,
               dbg_state
    );

    modport master (
        output i_req, i_start, i_tx0, i_tx1, i_eng_done, i_eng_rx,
        input  o_gnt, o_done, o_abort, o_rx, o_eng_start, o_eng_tx, o_spi_ss,
               dbg_state
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI byte engine and the flash chip select between the CPU I/O
// port (requester 0) and the flash loader (requester 1). Sessions are granted
// whole, round-robin on ties; the first byte of each session is screened for
// dual/quad-I/O opcodes; a watchdog revokes sessions that sit idle.
// All outputs are registered; dbg_state mirrors the FSM state.
module spi_bus_arbiter #(
    parameter int CS_HIGH_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic         i_clk,
    input logic         i_reset,
    spi_bus_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANT   = 3'd1,
        S_XFER    = 3'd2,
        S_RELEASE = 3'd3,
        S_BLOCKED = 3'd4
    } state_t;

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST =
        (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [7:0] HOLD_LAST = 8'(CS_HIGH_CYCLES - 1);

    // Opcodes that would switch the flash into multi-line I/O, which the
    // single-line engine cannot follow.
    function automatic logic is_forbidden(input logic [7:0] b);
        case (b)
            8'h3B, 8'h6B, 8'hEB, 8'hBB,
            8'h77, 8'h32, 8'h92, 8'h94: is_forbidden = 1'b1;
            default:                    is_forbidden = 1'b0;
        endcase
    endfunction

    state_t          state, state_d;
    logic            owner, owner_d;
    logic            last_owner, last_owner_d;
    logic            first_byte, first_byte_d;
    logic [WD_W-1:0] wdog, wdog_d;
    logic [7:0]      hold, hold_d;
    logic [1:0]      gnt, gnt_d;
    logic            ss, ss_d;
    logic [1:0]      done, done_d;
    logic [1:0]      abort, abort_d;
    logic            eng_start, eng_start_d;
    logic [7:0]      eng_tx, eng_tx_d;
    logic [7:0]      rx, rx_d;
    logic            pick;

    logic       req_own;
    logic       start_own;
    logic [7:0] tx_own;

    assign req_own   = bus.i_req[owner];
    assign start_own = bus.i_start[owner];
    assign tx_own    = owner ? bus.i_tx1 : bus.i_tx0;

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_d;
    end

    // Session bookkeeping and registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            first_byte <= 1'b1;
            wdog       <= '0;
            hold       <= '0;
            gnt        <= '0;
            ss         <= 1'b1;
            done       <= '0;
            abort      <= '0;
            eng_start  <= 1'b0;
            eng_tx     <= 8'hFF;
            rx         <= 8'hFF;
        end else begin
            owner      <= owner_d;
            last_owner <= last_owner_d;
            first_byte <= first_byte_d;
            wdog       <= wdog_d;
            hold       <= hold_d;
            gnt        <= gnt_d;
            ss         <= ss_d;
            done       <= done_d;
            abort      <= abort_d;
            eng_start  <= eng_start_d;
            eng_tx     <= eng_tx_d;
            rx         <= rx_d;
        end
    end

    // Next-state and next-output decode; strobes default low every cycle.
    always_comb begin
        state_d      = state;
        owner_d      = owner;
        last_owner_d = last_owner;
        first_byte_d = first_byte;
        wdog_d       = wdog;
        hold_d       = hold;
        gnt_d        = gnt;
        ss_d         = ss;
        done_d       = '0;
        abort_d      = '0;
        eng_start_d  = 1'b0;
        eng_tx_d     = eng_tx;
        rx_d         = rx;
        pick         = 1'b0;

        case (state)
            S_IDLE: begin
                if (|bus.i_req) begin
                    // On a tie the requester that did not own the bus last wins.
                    pick         = (bus.i_req == 2'b11) ? ~last_owner : bus.i_req[1];
                    owner_d      = pick;
                    gnt_d        = pick ? 2'b10 : 2'b01;
                    ss_d         = 1'b0;
                    first_byte_d = 1'b1;
                    wdog_d       = '0;
                    state_d      = S_GRANT;
                end
            end

            S_GRANT: begin
                if (!req_own) begin
                    // Dropping the request wins over a same-cycle start.
                    gnt_d   = '0;
                    ss_d    = 1'b1;
                    hold_d  = '0;
                    state_d = S_RELEASE;
                end else if (start_own) begin
                    if (first_byte && is_forbidden(tx_own)) begin
                        abort_d[owner] = 1'b1;
                        gnt_d          = '0;
                        ss_d           = 1'b1;
                        state_d        = S_BLOCKED;
                    end else begin
                        eng_tx_d     = tx_own;
                        eng_start_d  = 1'b1;
                        first_byte_d = 1'b0;
                        wdog_d       = '0;
                        state_d      = S_XFER;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (wdog == WD_LAST) begin
                        abort_d[owner] = 1'b1;
                        gnt_d          = '0;
                        ss_d           = 1'b1;
                        state_d        = S_BLOCKED;
                    end else begin
                        wdog_d = wdog + WD_W'(1);
                    end
                end
            end

            S_XFER: begin
                // The byte in flight always completes, even if the request drops.
                if (bus.i_eng_done) begin
                    rx_d          = bus.i_eng_rx;
                    done_d[owner] = 1'b1;
                    wdog_d        = '0;
                    if (req_own) begin
                        state_d = S_GRANT;
                    end else begin
                        gnt_d   = '0;
                        ss_d    = 1'b1;
                        hold_d  = '0;
                        state_d = S_RELEASE;
                    end
                end
            end

            S_RELEASE: begin
                gnt_d        = '0;
                ss_d         = 1'b1;
                last_owner_d = owner;
                if (hold == HOLD_LAST) state_d = S_IDLE;
                else                   hold_d  = hold + 8'd1;
            end

            S_BLOCKED: begin
                gnt_d = '0;
                ss_d  = 1'b1;
                if (!req_own) begin
                    hold_d  = '0;
                    state_d = S_RELEASE;
                end
            end

            default: begin
                gnt_d   = '0;
                ss_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.o_gnt       = gnt;
    assign bus.o_spi_ss    = ss;
    assign bus.o_done      = done;
    assign bus.o_abort     = abort;
    assign bus.o_eng_start = eng_start;
    assign bus.o_eng_tx    = eng_tx;
    assign bus.o_rx        = rx;
    assign bus.dbg_state   = state;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: one instance with a short watchdog, one with the
// watchdog disabled. Inputs change and outputs are sampled 1 ns after the
// rising edge. Forwarded bytes and returned bytes go through expected queues.
module tb_spi_bus_arbiter;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GRANT   = 3'd1;
    localparam logic [2:0] ST_XFER    = 3'd2;
    localparam logic [2:0] ST_BLOCKED = 3'd4;

    logic i_clk   = 1'b0;
    logic i_reset = 1'b1;

    spi_bus_arbiter_if bus ();
    spi_bus_arbiter_if bus2 ();

    spi_bus_arbiter #(.CS_HIGH_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .bus(bus)
    );
    spi_bus_arbiter #(.CS_HIGH_CYCLES(4), .TIMEOUT_CYCLES(0)) dut_nowd (
        .i_clk(i_clk), .i_reset(i_reset), .bus(bus2)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] eng_exp_q[$];
    logic [7:0] rx_exp_q[$];
    logic [7:0] exp_b;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic init_inputs();
        bus.i_req = '0;  bus.i_start = '0; bus.i_tx0 = 8'hFF; bus.i_tx1 = 8'hFF;
        bus.i_eng_done = 1'b0; bus.i_eng_rx = 8'h00;
        bus2.i_req = '0; bus2.i_start = '0; bus2.i_tx0 = 8'hFF; bus2.i_tx1 = 8'hFF;
        bus2.i_eng_done = 1'b0; bus2.i_eng_rx = 8'h00;
    endtask

    task automatic pulse_reset();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        tick();
    endtask

    // One-cycle byte start from requester `who`; `fwd` says whether the
    // arbiter is expected to pass it to the engine.
    task automatic drive_start(input int who, input logic [7:0] b, input bit fwd);
        if (who == 0) begin bus.i_start = 2'b01; bus.i_tx0 = b; end
        else          begin bus.i_start = 2'b10; bus.i_tx1 = b; end
        if (fwd) eng_exp_q.push_back(b);
        tick();
        bus.i_start = '0;
    endtask

    // Engine finishes the outstanding byte with received value b.
    task automatic engine_reply(input logic [7:0] b);
        bus.i_eng_done = 1'b1;
        bus.i_eng_rx   = b;
        rx_exp_q.push_back(b);
        tick();
        bus.i_eng_done = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, output int cycles);
        cycles = 0;
        while (bus.dbg_state !== st && cycles < 50) begin
            tick();
            cycles++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        i_reset = 1'b1;
        tick();
        n_tests++; if (bus.o_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", bus.o_gnt); end
        n_tests++; if (bus.o_spi_ss !== 1'b1) begin n_fail++; $display("FAIL reset_ss: got %b expected 1", bus.o_spi_ss); end
        n_tests++; if (bus.o_rx !== 8'hFF) begin n_fail++; $display("FAIL reset_rx: got %h expected ff", bus.o_rx); end
        n_tests++; if (bus.o_eng_tx !== 8'hFF) begin n_fail++; $display("FAIL reset_eng_tx: got %h expected ff", bus.o_eng_tx); end
        n_tests++; if ({bus.o_eng_start, bus.o_done, bus.o_abort} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes: got %b expected 00000", {bus.o_eng_start, bus.o_done, bus.o_abort}); end
        n_tests++; if (bus.dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.dbg_state); end
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_single_byte();
        int c;
        bus.i_req = 2'b01;
        tick();
        n_tests++; if (bus.o_gnt !== 2'b01 || bus.o_spi_ss !== 1'b0) begin n_fail++; $display("FAIL single_grant: got gnt=%b ss=%b expected gnt=01 ss=0", bus.o_gnt, bus.o_spi_ss); end
        drive_start(0, 8'h03, 1);
        exp_b = eng_exp_q.pop_front();
        n_tests++; if (bus.o_eng_start !== 1'b1 || bus.o_eng_tx !== exp_b) begin n_fail++; $display("FAIL single_eng: got start=%b tx=%h expected start=1 tx=%h", bus.o_eng_start, bus.o_eng_tx, exp_b); end
        tick();
        n_tests++; if (bus.o_eng_start !== 1'b0 || bus.o_eng_tx !== exp_b) begin n_fail++; $display("FAIL single_eng_hold: got start=%b tx=%h expected start=0 tx=%h", bus.o_eng_start, bus.o_eng_tx, exp_b); end
        engine_reply(8'hA5);
        exp_b = rx_exp_q.pop_front();
        n_tests++; if (bus.o_done !== 2'b01 || bus.o_rx !== exp_b) begin n_fail++; $display("FAIL single_done: got done=%b rx=%h expected done=01 rx=%h", bus.o_done, bus.o_rx, exp_b); end
        tick();
        n_tests++; if (bus.o_done !== 2'b00 || bus.o_rx !== 8'hA5) begin n_fail++; $display("FAIL single_done_pulse: got done=%b rx=%h expected done=00 rx=a5", bus.o_done, bus.o_rx); end
        bus.i_req = 2'b00;
        tick();
        n_tests++; if (bus.o_gnt !== 2'b00 || bus.o_spi_ss !== 1'b1) begin n_fail++; $display("FAIL single_release: got gnt=%b ss=%b expected gnt=00 ss=1", bus.o_gnt, bus.o_spi_ss); end
        wait_state(ST_IDLE, c);
        n_tests++; if (c >= 50) begin n_fail++; $display("FAIL single_idle: got %0d cycles expected <50", c); end
    endtask

    task automatic test_round_robin();
        int hi;
        int c;
        pulse_reset();
        bus.i_req = 2'b11;
        tick();
        n_tests++; if (bus.o_gnt !== 2'b01) begin n_fail++; $display("FAIL rr_first_tie: got %b expected 01", bus.o_gnt); end
        bus.i_req = 2'b00;
        tick();
        bus.i_req = 2'b11;
        hi = (bus.o_spi_ss === 1'b1) ? 1 : 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.o_gnt !== 2'b00) break;
            if (bus.o_spi_ss === 1'b1) hi++;
        end
        n_tests++; if (bus.o_gnt !== 2'b10) begin n_fail++; $display("FAIL rr_second_tie: got %b expected 10", bus.o_gnt); end
        n_tests++; if (hi < 4) begin n_fail++; $display("FAIL rr_cs_high: got %0d cycles expected >=4", hi); end
        bus.i_req = 2'b00;
        tick();
        wait_state(ST_IDLE, c);
        n_tests++; if (c >= 50) begin n_fail++; $display("FAIL rr_idle: got %0d cycles expected <50", c); end
    endtask

    task automatic test_forbidden();
        int c;
        bus.i_req = 2'b10;
        tick();
        n_tests++; if (bus.o_gnt !== 2'b10) begin n_fail++; $display("FAIL forb_grant: got %b expected 10", bus.o_gnt); end
        drive_start(1, 8'hEB, 0);
        n_tests++; if (bus.o_abort !== 2'b10 || bus.o_eng_start !== 1'b0) begin n_fail++; $display("FAIL forb_abort: got abort=%b start=%b expected abort=10 start=0", bus.o_abort, bus.o_eng_start); end
        n_tests++; if (bus.o_spi_ss !== 1'b1 || bus.o_gnt !== 2'b00) begin n_fail++; $display("FAIL forb_cs: got ss=%b gnt=%b expected ss=1 gnt=00", bus.o_spi_ss, bus.o_gnt); end
        bus.i_req = 2'b11;
        repeat (6) tick();
        n_tests++; if (bus.dbg_state !== ST_BLOCKED || bus.o_gnt !== 2'b00 || bus.o_abort !== 2'b00) begin n_fail++; $display("FAIL forb_blocked: got st=%0d gnt=%b abort=%b expected st=4 gnt=00 abort=00", bus.dbg_state, bus.o_gnt, bus.o_abort); end
        bus.i_req = 2'b01;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.o_gnt !== 2'b00) break;
        end
        n_tests++; if (bus.o_gnt !== 2'b01) begin n_fail++; $display("FAIL forb_other_after: got %b expected 01", bus.o_gnt); end
        bus.i_req = 2'b00;
        tick();
        wait_state(ST_IDLE, c);
        // 0xEB as a second byte is just data.
        bus.i_req = 2'b10;
        tick();
        drive_start(1, 8'h03, 1);
        exp_b = eng_exp_q.pop_front();
        n_tests++; if (bus.o_eng_start !== 1'b1 || bus.o_eng_tx !== exp_b) begin n_fail++; $display("FAIL second_first_eng: got start=%b tx=%h expected start=1 tx=%h", bus.o_eng_start, bus.o_eng_tx, exp_b); end
        engine_reply(8'h3C);
        exp_b = rx_exp_q.pop_front();
        n_tests++; if (bus.o_done !== 2'b10 || bus.o_rx !== exp_b) begin n_fail++; $display("FAIL second_first_done: got done=%b rx=%h expected done=10 rx=%h", bus.o_done, bus.o_rx, exp_b); end
        drive_start(1, 8'hEB, 1);
        exp_b = eng_exp_q.pop_front();
        n_tests++; if (bus.o_eng_start !== 1'b1 || bus.o_eng_tx !== exp_b || bus.o_abort !== 2'b00) begin n_fail++; $display("FAIL second_eb_fwd: got start=%b tx=%h abort=%b expected start=1 tx=%h abort=00", bus.o_eng_start, bus.o_eng_tx, bus.o_abort, exp_b); end
        engine_reply(8'hC3);
        exp_b = rx_exp_q.pop_front();
        n_tests++; if (bus.o_done !== 2'b10 || bus.o_rx !== exp_b) begin n_fail++; $display("FAIL second_eb_done: got done=%b rx=%h expected done=10 rx=%h", bus.o_done, bus.o_rx, exp_b); end
        drive_start(0, 8'h06, 0);
        n_tests++; if (bus.o_eng_start !== 1'b0 || bus.dbg_state !== ST_GRANT) begin n_fail++; $display("FAIL nonowner_grant: got start=%b st=%0d expected start=0 st=1", bus.o_eng_start, bus.dbg_state); end
        bus.i_req = 2'b00;
        tick();
        wait_state(ST_IDLE, c);
        n_tests++; if (c >= 50) begin n_fail++; $display("FAIL forb_idle: got %0d cycles expected <50", c); end
    endtask

    task automatic test_drop_mid_byte();
        int c;
        bus.i_req = 2'b01;
        tick();
        drive_start(0, 8'h9F, 1);
        exp_b = eng_exp_q.pop_front();
        n_tests++; if (bus.o_eng_start !== 1'b1 || bus.o_eng_tx !== exp_b) begin n_fail++; $display("FAIL drop_eng: got start=%b tx=%h expected start=1 tx=%h", bus.o_eng_start, bus.o_eng_tx, exp_b); end
        bus.i_req = 2'b00;
        drive_start(1, 8'h55, 0);
        tick();
        n_tests++; if (bus.o_eng_start !== 1'b0 || bus.o_gnt !== 2'b01 || bus.o_spi_ss !== 1'b0 || bus.dbg_state !== ST_XFER) begin n_fail++; $display("FAIL drop_in_flight: got start=%b gnt=%b ss=%b st=%0d expected start=0 gnt=01 ss=0 st=2", bus.o_eng_start, bus.o_gnt, bus.o_spi_ss, bus.dbg_state); end
        engine_reply(8'h5A);
        exp_b = rx_exp_q.pop_front();
        n_tests++; if (bus.o_done !== 2'b01 || bus.o_rx !== exp_b) begin n_fail++; $display("FAIL drop_done: got done=%b rx=%h expected done=01 rx=%h", bus.o_done, bus.o_rx, exp_b); end
        n_tests++; if (bus.o_gnt !== 2'b00 || bus.o_spi_ss !== 1'b1) begin n_fail++; $display("FAIL drop_release: got gnt=%b ss=%b expected gnt=00 ss=1", bus.o_gnt, bus.o_spi_ss); end
        wait_state(ST_IDLE, c);
    endtask

    task automatic test_timeout();
        int cyc;
        int c;
        bus.i_req = 2'b01;
        tick();
        n_tests++; if (bus.o_gnt !== 2'b01) begin n_fail++; $display("FAIL wd_grant: got %b expected 01", bus.o_gnt); end
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            cyc++;
            if (bus.o_abort !== 2'b00) break;
        end
        n_tests++; if (cyc !== 20 || bus.o_abort !== 2'b01) begin n_fail++; $display("FAIL wd_abort: got cycle=%0d abort=%b expected cycle=20 abort=01", cyc, bus.o_abort); end
        n_tests++; if (bus.o_spi_ss !== 1'b1 || bus.o_gnt !== 2'b00) begin n_fail++; $display("FAIL wd_cs: got ss=%b gnt=%b expected ss=1 gnt=00", bus.o_spi_ss, bus.o_gnt); end
        bus.i_req = 2'b00;
        tick();
        wait_state(ST_IDLE, c);
    endtask

    task automatic test_no_timeout();
        bit seen;
        bus2.i_req = 2'b01;
        tick();
        n_tests++; if (bus2.o_gnt !== 2'b01) begin n_fail++; $display("FAIL nowd_grant: got %b expected 01", bus2.o_gnt); end
        seen = 1'b0;
        repeat (1000) begin
            tick();
            if (bus2.o_abort !== 2'b00) seen = 1'b1;
        end
        n_tests++; if (seen !== 1'b0 || bus2.o_gnt !== 2'b01 || bus2.o_spi_ss !== 1'b0) begin n_fail++; $display("FAIL nowd_hold: got abort_seen=%b gnt=%b ss=%b expected 0 01 0", seen, bus2.o_gnt, bus2.o_spi_ss); end
        bus2.i_req = 2'b00;
        tick();
    endtask

    task automatic test_async_reset();
        int c;
        bus.i_req = 2'b01;
        tick();
        drive_start(0, 8'h0B, 1);
        exp_b = eng_exp_q.pop_front();
        n_tests++; if (bus.o_eng_start !== 1'b1 || bus.o_eng_tx !== exp_b) begin n_fail++; $display("FAIL arst_eng: got start=%b tx=%h expected start=1 tx=%h", bus.o_eng_start, bus.o_eng_tx, exp_b); end
        #2;
        i_reset = 1'b1;
        #1;
        n_tests++; if (bus.o_spi_ss !== 1'b1 || bus.o_gnt !== 2'b00 || bus.dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL arst_async: got ss=%b gnt=%b st=%0d expected ss=1 gnt=00 st=0", bus.o_spi_ss, bus.o_gnt, bus.dbg_state); end
        bus.i_req = 2'b00;
        tick();
        i_reset = 1'b0;
        tick();
        bus.i_req = 2'b10;
        tick();
        n_tests++; if (bus.o_gnt !== 2'b10 || bus.o_spi_ss !== 1'b0) begin n_fail++; $display("FAIL arst_regrant: got gnt=%b ss=%b expected gnt=10 ss=0", bus.o_gnt, bus.o_spi_ss); end
        bus.i_req = 2'b00;
        tick();
        wait_state(ST_IDLE, c);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        init_inputs();
        test_reset();
        test_single_byte();
        test_round_robin();
        test_forbidden();
        test_drop_mid_byte();
        test_timeout();
        test_no_timeout();
        test_async_reset();
        n_tests++; if (eng_exp_q.size() + rx_exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", eng_exp_q.size() + rx_exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
